pipeline_hazard_ctrl: RTL and testbench

//   Central stall/flush/forward sequencer for the 5-stage IF/ID/EX/MM/WB pipeline.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 42 ++++
 rtl/pipeline_hazard_ctrl_if.sv | 56 +++++
 rtl/pipeline_hazard_ctrl_fwd_unit.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the 5-stage pipeline hazard sequencer.
// Forward-select encoding and controller state encoding live here.
package pipe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_MM = 2'd1,
    FWD_WB = 2'd2
  } fwd_sel_e;

  // True when a live source register is produced by a writing stage.
  // x0 is hardwired to zero and never creates a dependency.
  function automatic logic rd_hit(
    input logic [4:0] rs,
    input logic [4:0] rd,
    input logic       en
  );
    return en && (rd != REG_ZERO) && (rs == rd);
  endfunction

  // Youngest producer wins: MM holds newer data than WB.
  function automatic fwd_sel_e fwd_pick(
    input logic [4:0] rs,
    input logic [4:0] mm_rd,
    input logic       mm_we,
    input logic [4:0] wb_rd,
    input logic       wb_we
  );
    if (rd_hit(rs, mm_rd, mm_we)) return FWD_MM;
    if (rd_hit(rs, wb_rd, wb_we)) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard sequencer.
// master = datapath side, slave = hazard controller side.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_WIDTH = 32
);

  logic [4:0]           id_rs1;
  logic [4:0]           id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic [4:0]           ex_rs1;
  logic [4:0]           ex_rs2;
  logic [4:0]           ex_rd;
  logic                 ex_reg_write;
  logic                 ex_mem_read;
  logic [4:0]           mm_rd;
  logic                 mm_reg_write;
  logic [4:0]           wb_rd;
  logic                 wb_reg_write;
  logic                 br_taken;
  logic                 dmem_req;
  logic                 dmem_ready;

  logic                 pc_stall;
  logic                 if_id_stall;
  logic                 if_id_flush;
  logic                 id_ex_stall;
  logic                 id_ex_flush;
  logic                 ex_mm_stall;
  logic                 mm_wb_flush;
  logic [1:0]           fwd_a_sel;
  logic [1:0]           fwd_b_sel;
  logic                 halted;
  logic [CNT_WIDTH-1:0] stall_cycles;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
    output mm_rd, mm_reg_write, wb_rd, wb_reg_write,
    output br_taken, dmem_req, dmem_ready,
    input  pc_stall, if_id_stall, if_id_flush,
    input  id_ex_stall, id_ex_flush, ex_mm_stall, mm_wb_flush,
    input  fwd_a_sel, fwd_b_sel, halted, stall_cycles
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
    input  mm_rd, mm_reg_write, wb_rd, wb_reg_write,
    input  br_taken, dmem_req, dmem_ready,
    output pc_stall, if_id_stall, if_id_flush,
    output id_ex_stall, id_ex_flush, ex_mm_stall, mm_wb_flush,
    output fwd_a_sel, fwd_b_sel, halted, stall_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Combinational EX operand forwarding compare for both ALU operands.
// MM results take precedence over WB results; x0 never forwards.
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs1_i,
  input  logic [4:0] ex_rs2_i,
  input  logic [4:0] mm_rd_i,
  input  logic       mm_reg_write_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_reg_write_i,
  output fwd_sel_e   fwd_a_sel_o,
  output fwd_sel_e   fwd_b_sel_o
);

  assign fwd_a_sel_o = fwd_pick(ex_rs1_i, mm_rd_i, mm_reg_write_i,
                                wb_rd_i, wb_reg_write_i);

  assign fwd_b_sel_o = fwd_pick(ex_rs2_i, mm_rd_i, mm_reg_write_i,
                                wb_rd_i, wb_reg_write_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward sequencer with memory-wait watchdog and stall counter.
// Define PIPE_FWD_EN to enable operand forwarding (else RAW hazards stall).
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz_if
);

`ifdef PIPE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  localparam logic [1:0] S_RUN      = ST_RUN;
  localparam logic [1:0] S_MEM_WAIT = ST_MEM_WAIT;
  localparam logic [1:0] S_HALT     = ST_HALT;

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [WAIT_W-1:0]    wait_q;
  logic [WAIT_W-1:0]    wait_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] stall_cnt_d;

  logic     halt;
  logic     mem_wait;
  logic     ex_hit;
  logic     mm_hit;
  logic     wb_hit;
  logic     ld_use;
  logic     raw_hz;
  logic     data_hz;
  logic     sel_halt;
  logic     sel_mw;
  logic     sel_br;
  logic     sel_hz;
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  logic pc_stall;
  logic if_id_stall;
  logic if_id_flush;
  logic id_ex_stall;
  logic id_ex_flush;
  logic ex_mm_stall;
  logic mm_wb_flush;

  assign halt     = (state_q == S_HALT);
  assign mem_wait = hz_if.dmem_req & ~hz_if.dmem_ready;

  // Does the ID instruction actually read a given producer's rd.
  assign ex_hit = rd_hit(hz_if.id_rs1, hz_if.ex_rd, hz_if.id_use_rs1)
                | rd_hit(hz_if.id_rs2, hz_if.ex_rd, hz_if.id_use_rs2);
  assign mm_hit = rd_hit(hz_if.id_rs1, hz_if.mm_rd, hz_if.id_use_rs1)
                | rd_hit(hz_if.id_rs2, hz_if.mm_rd, hz_if.id_use_rs2);
  assign wb_hit = rd_hit(hz_if.id_rs1, hz_if.wb_rd, hz_if.id_use_rs1)
                | rd_hit(hz_if.id_rs2, hz_if.wb_rd, hz_if.id_use_rs2);

  assign ld_use = ex_hit & hz_if.ex_mem_read;

  assign raw_hz = (ex_hit & hz_if.ex_reg_write)
                | (mm_hit & hz_if.mm_reg_write)
                | (wb_hit & hz_if.wb_reg_write);

  // Without forwarding every in-flight producer must drain first.
  assign data_hz = ld_use | (~FWD_ON & raw_hz);

  // Mutually exclusive priority terms; reset silences everything.
  assign sel_halt = ~rst & halt;
  assign sel_mw   = ~rst & ~halt & mem_wait;
  assign sel_br   = ~rst & ~halt & ~mem_wait & hz_if.br_taken;
  assign sel_hz   = ~rst & ~halt & ~mem_wait & ~hz_if.br_taken & data_hz;

  fwd_unit u_fwd (
    .ex_rs1_i       (hz_if.ex_rs1),
    .ex_rs2_i       (hz_if.ex_rs2),
    .mm_rd_i        (hz_if.mm_rd),
    .mm_reg_write_i (hz_if.mm_reg_write),
    .wb_rd_i        (hz_if.wb_rd),
    .wb_reg_write_i (hz_if.wb_reg_write),
    .fwd_a_sel_o    (fwd_a),
    .fwd_b_sel_o    (fwd_b)
  );

  // Priority-encode the pipeline stall/flush controls.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    ex_mm_stall = 1'b0;
    mm_wb_flush = 1'b0;
    unique case (1'b1)
      sel_halt, sel_mw: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_stall = 1'b1;
        ex_mm_stall = 1'b1;
        mm_wb_flush = 1'b1;
      end
      sel_br: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      sel_hz: begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz_if.pc_stall     = pc_stall;
  assign hz_if.if_id_stall  = if_id_stall;
  assign hz_if.if_id_flush  = if_id_flush;
  assign hz_if.id_ex_stall  = id_ex_stall;
  assign hz_if.id_ex_flush  = id_ex_flush;
  assign hz_if.ex_mm_stall  = ex_mm_stall;
  assign hz_if.mm_wb_flush  = mm_wb_flush;
  assign hz_if.halted       = sel_halt;
  assign hz_if.stall_cycles = stall_cnt_q;

  assign hz_if.fwd_a_sel = (FWD_ON && !rst) ? fwd_a : FWD_RF;
  assign hz_if.fwd_b_sel = (FWD_ON && !rst) ? fwd_b : FWD_RF;

  // Watchdog FSM: wait_q counts consecutive wait cycles including the
  // RUN cycle that first saw the wait, so HALT follows the Nth one.
  // A dropped request also ends the wait rather than feeding the watchdog.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d = S_MEM_WAIT;
          wait_d  = WAIT_ONE;
        end
      end
      S_MEM_WAIT: begin
        if (!mem_wait) begin
          state_d = S_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Saturating count of cycles the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  // State, watchdog and performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized model check.
// dut_a uses default sizing, dut_b a 4-cycle watchdog and 4-bit counter.
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_WIDTH(32)) ia ();
  pipeline_hazard_ctrl_if #(.CNT_WIDTH(4))  ib ();

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(256), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .hz_if(ia)
  );
  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .hz_if(ib)
  );

  typedef struct packed {
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       use1;
    logic       use2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_we;
    logic       ex_ld;
    logic [4:0] mm_rd;
    logic       mm_we;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  stim_t s;
  int checks = 0;
  int errors = 0;

  assign ia.id_rs1 = s.id_rs1;     assign ib.id_rs1 = s.id_rs1;
  assign ia.id_rs2 = s.id_rs2;     assign ib.id_rs2 = s.id_rs2;
  assign ia.id_use_rs1 = s.use1;   assign ib.id_use_rs1 = s.use1;
  assign ia.id_use_rs2 = s.use2;   assign ib.id_use_rs2 = s.use2;
  assign ia.ex_rs1 = s.ex_rs1;     assign ib.ex_rs1 = s.ex_rs1;
  assign ia.ex_rs2 = s.ex_rs2;     assign ib.ex_rs2 = s.ex_rs2;
  assign ia.ex_rd = s.ex_rd;       assign ib.ex_rd = s.ex_rd;
  assign ia.ex_reg_write = s.ex_we; assign ib.ex_reg_write = s.ex_we;
  assign ia.ex_mem_read = s.ex_ld; assign ib.ex_mem_read = s.ex_ld;
  assign ia.mm_rd = s.mm_rd;       assign ib.mm_rd = s.mm_rd;
  assign ia.mm_reg_write = s.mm_we; assign ib.mm_reg_write = s.mm_we;
  assign ia.wb_rd = s.wb_rd;       assign ib.wb_rd = s.wb_rd;
  assign ia.wb_reg_write = s.wb_we; assign ib.wb_reg_write = s.wb_we;
  assign ia.br_taken = s.br;       assign ib.br_taken = s.br;
  assign ia.dmem_req = s.req;      assign ib.dmem_req = s.req;
  assign ia.dmem_ready = s.rdy;    assign ib.dmem_ready = s.rdy;

  // {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  //  ex_mm_stall, mm_wb_flush, fwd_a[1:0], fwd_b[1:0], halted}
  logic [11:0] oa, ob;
  assign oa = {ia.pc_stall, ia.if_id_stall, ia.if_id_flush, ia.id_ex_stall,
               ia.id_ex_flush, ia.ex_mm_stall, ia.mm_wb_flush,
               ia.fwd_a_sel, ia.fwd_b_sel, ia.halted};
  assign ob = {ib.pc_stall, ib.if_id_stall, ib.if_id_flush, ib.id_ex_stall,
               ib.id_ex_flush, ib.ex_mm_stall, ib.mm_wb_flush,
               ib.fwd_a_sel, ib.fwd_b_sel, ib.halted};

  localparam logic [6:0] CTL_NONE = 7'b0000000;
  localparam logic [6:0] CTL_HOLD = 7'b1101011;
  localparam logic [6:0] CTL_BR   = 7'b0010100;
  localparam logic [6:0] CTL_LU   = 7'b1100100;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic bit reads(stim_t t, logic [4:0] r);
    return (r != 5'd0) &&
           ((t.use1 && t.id_rs1 == r) || (t.use2 && t.id_rs2 == r));
  endfunction

  function automatic logic [1:0] src(stim_t t, logic [4:0] rs);
    if (!FWD || rs == 5'd0) return 2'd0;
    if (t.mm_we && t.mm_rd == rs) return 2'd1;
    if (t.wb_we && t.wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [11:0] model(stim_t t, bit hlt);
    bit mw;
    bit hz;
    logic [6:0] ctl;
    mw = t.req && !t.rdy;
    hz = t.ex_ld && reads(t, t.ex_rd);
    if (!FWD)
      hz = hz || (t.ex_we && reads(t, t.ex_rd)) ||
           (t.mm_we && reads(t, t.mm_rd)) || (t.wb_we && reads(t, t.wb_rd));
    if (hlt || mw)  ctl = CTL_HOLD;
    else if (t.br)  ctl = CTL_BR;
    else if (hz)    ctl = CTL_LU;
    else            ctl = CTL_NONE;
    return {ctl, src(t, t.ex_rs1), src(t, t.ex_rs2), hlt};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    s = '0;
    s.req = 1'b1; s.br = 1'b1; s.ex_ld = 1'b1; s.ex_rd = 5'd5;
    s.id_rs1 = 5'd5; s.use1 = 1'b1;
    s.mm_rd = 5'd3; s.mm_we = 1'b1; s.ex_rs1 = 5'd3;
    rst = 1'b1;
    #2;
    checks++;
    if (oa !== 12'd0) begin
      errors++; $display("FAIL reset_out_a got %h exp 000", oa);
    end
    checks++;
    if (ob !== 12'd0) begin
      errors++; $display("FAIL reset_out_b got %h exp 000", ob);
    end
    tick();
    checks++;
    if (ia.stall_cycles !== 32'd0 || ib.stall_cycles !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d exp 0/0",
               ia.stall_cycles, ib.stall_cycles);
    end
    checks++;
    if (oa !== 12'd0) begin
      errors++; $display("FAIL reset_hold_a got %h exp 000", oa);
    end
    rst = 1'b0;
    s = '0;
    #1;
  endtask

  task automatic test_load_use();
    do_reset();
    s.ex_ld = 1'b1; s.ex_we = 1'b1; s.ex_rd = 5'd5;
    s.id_rs1 = 5'd5; s.id_rs2 = 5'd1; s.use1 = 1'b1; s.use2 = 1'b1;
    #1;
    checks++;
    if (oa[11:5] !== CTL_LU) begin
      errors++; $display("FAIL load_use_bubble got %b exp %b", oa[11:5], CTL_LU);
    end
    tick();
    s.ex_ld = 1'b0; s.ex_we = 1'b0; s.ex_rd = 5'd0;
    s.mm_rd = 5'd5; s.mm_we = 1'b1;
    #1;
    checks++;
    if (ia.pc_stall !== (FWD ? 1'b0 : 1'b1)) begin
      errors++;
      $display("FAIL load_use_after got %b exp %b", ia.pc_stall, !FWD);
    end
    tick();
    s.use1 = 1'b0; s.use2 = 1'b0;
    s.ex_rs1 = 5'd5; s.ex_rs2 = 5'd1;
    #1;
    checks++;
    if (ia.fwd_a_sel !== (FWD ? 2'd1 : 2'd0) || ia.fwd_b_sel !== 2'd0) begin
      errors++;
      $display("FAIL load_use_fwd got %0d/%0d exp %0d/0",
               ia.fwd_a_sel, ia.fwd_b_sel, FWD ? 1 : 0);
    end
    checks++;
    if (ia.stall_cycles !== (FWD ? 32'd1 : 32'd2)) begin
      errors++;
      $display("FAIL load_use_cnt got %0d exp %0d",
               ia.stall_cycles, FWD ? 1 : 2);
    end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    s.mm_rd = 5'd3; s.mm_we = 1'b1; s.wb_rd = 5'd3; s.wb_we = 1'b1;
    s.ex_rs2 = 5'd3; s.ex_rs1 = 5'd0;
    #1;
    checks++;
    if (ia.fwd_b_sel !== (FWD ? 2'd1 : 2'd0) || ia.fwd_a_sel !== 2'd0) begin
      errors++;
      $display("FAIL fwd_mm_first got %0d/%0d", ia.fwd_a_sel, ia.fwd_b_sel);
    end
    s.mm_we = 1'b0;
    #1;
    checks++;
    if (ia.fwd_b_sel !== (FWD ? 2'd2 : 2'd0)) begin
      errors++; $display("FAIL fwd_wb got %0d", ia.fwd_b_sel);
    end
    s.mm_rd = 5'd0; s.mm_we = 1'b1; s.wb_rd = 5'd0; s.wb_we = 1'b1;
    s.ex_rs1 = 5'd0; s.ex_rs2 = 5'd0;
    #1;
    checks++;
    if (ia.fwd_a_sel !== 2'd0 || ia.fwd_b_sel !== 2'd0) begin
      errors++;
      $display("FAIL fwd_x0 got %0d/%0d exp 0/0", ia.fwd_a_sel, ia.fwd_b_sel);
    end
    s.wb_rd = 5'd9; s.ex_rs1 = 5'd9;
    #1;
    checks++;
    if (ia.fwd_a_sel !== (FWD ? 2'd2 : 2'd0) || ia.pc_stall !== 1'b0) begin
      errors++;
      $display("FAIL fwd_wb_a got %0d stall %b", ia.fwd_a_sel, ia.pc_stall);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    s.ex_ld = 1'b1; s.ex_we = 1'b1; s.ex_rd = 5'd5;
    s.id_rs1 = 5'd5; s.use1 = 1'b1; s.br = 1'b1;
    #1;
    checks++;
    if (oa[11:5] !== CTL_BR) begin
      errors++; $display("FAIL redirect_over_lu got %b exp %b", oa[11:5], CTL_BR);
    end
    s.req = 1'b1;
    #1;
    checks++;
    if (oa[11:5] !== CTL_HOLD) begin
      errors++; $display("FAIL memwait_over_br got %b exp %b", oa[11:5], CTL_HOLD);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    s.req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (oa[11:5] !== CTL_HOLD || ia.halted !== 1'b0) begin
        errors++;
        $display("FAIL mem_wait_%0d got %b halt %b exp %b",
                 i, oa[11:5], ia.halted, CTL_HOLD);
      end
      tick();
    end
    s.rdy = 1'b1;
    #1;
    checks++;
    if (oa[11:5] !== CTL_NONE || ia.stall_cycles !== 32'd5) begin
      errors++;
      $display("FAIL mem_wait_done got %b cnt %0d exp 0 cnt 5",
               oa[11:5], ia.stall_cycles);
    end
    tick();
    s.req = 1'b0; s.rdy = 1'b0;
    #1;
    checks++;
    if (oa[11:5] !== CTL_NONE || ia.stall_cycles !== 32'd5) begin
      errors++;
      $display("FAIL mem_wait_run got %b cnt %0d exp 0 cnt 5",
               oa[11:5], ia.stall_cycles);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    s.req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ib.halted !== 1'b0 || ib.pc_stall !== 1'b1) begin
        errors++;
        $display("FAIL timeout_pre_%0d halt %b stall %b exp 0 1",
                 i, ib.halted, ib.pc_stall);
      end
      tick();
    end
    #1;
    checks++;
    if (ob[11:5] !== CTL_HOLD || ib.halted !== 1'b1 || ia.halted !== 1'b0) begin
      errors++;
      $display("FAIL timeout_halt got %b halt %b/%b exp %b 1/0",
               ob[11:5], ib.halted, ia.halted, CTL_HOLD);
    end
    s.req = 1'b0; s.br = 1'b1;
    tick();
    checks++;
    if (ib.halted !== 1'b1 || ib.if_id_flush !== 1'b0 || ia.if_id_flush !== 1'b1) begin
      errors++;
      $display("FAIL halt_terminal halt %b flush %b/%b exp 1 0/1",
               ib.halted, ib.if_id_flush, ia.if_id_flush);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ob !== 12'd0) begin
      errors++; $display("FAIL halt_rst got %h exp 000", ob);
    end
    tick();
    rst = 1'b0; s = '0;
    #1;
    checks++;
    if (ib.halted !== 1'b0 || ib.pc_stall !== 1'b0) begin
      errors++;
      $display("FAIL halt_recover halt %b stall %b exp 0 0",
               ib.halted, ib.pc_stall);
    end
  endtask

  task automatic test_raw_nofwd();
    do_reset();
    s.wb_rd = 5'd7; s.wb_we = 1'b1; s.id_rs1 = 5'd7; s.use1 = 1'b1;
    #1;
    checks++;
    if (oa[11:5] !== (FWD ? CTL_NONE : CTL_LU)) begin
      errors++; $display("FAIL raw_wb got %b fwd=%0d", oa[11:5], FWD);
    end
    tick();
    s.wb_we = 1'b0; s.wb_rd = 5'd0;
    #1;
    checks++;
    if (ia.pc_stall !== 1'b0) begin
      errors++; $display("FAIL raw_clear got %b exp 0", ia.pc_stall);
    end
    s.wb_we = 1'b1; s.id_rs1 = 5'd0;
    #1;
    checks++;
    if (ia.pc_stall !== 1'b0) begin
      errors++; $display("FAIL raw_x0 got %b exp 0", ia.pc_stall);
    end
    s.wb_rd = 5'd7; s.id_rs1 = 5'd7; s.use1 = 1'b0;
    #1;
    checks++;
    if (ia.pc_stall !== 1'b0) begin
      errors++; $display("FAIL raw_unused got %b exp 0", ia.pc_stall);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    s.ex_ld = 1'b1; s.ex_rd = 5'd4; s.id_rs2 = 5'd4; s.use2 = 1'b1;
    #1;
    repeat (20) tick();
    checks++;
    if (ib.stall_cycles !== 4'hF || ia.stall_cycles !== 32'd20) begin
      errors++;
      $display("FAIL stall_sat got %0d/%0d exp 15/20",
               ib.stall_cycles, ia.stall_cycles);
    end
  endtask

  task automatic test_random();
    bit     hlt[2];
    int     run[2];
    longint cnt[2];
    int     to[2];
    longint cmax[2];
    logic [11:0] e[2];
    to   = '{256, 4};
    cmax = '{64'hFFFF_FFFF, 64'd15};
    for (int n = 0; n < 600; n++) begin
      if (n == 0 || n == 300) begin
        do_reset();
        for (int k = 0; k < 2; k++) begin
          hlt[k] = 1'b0; run[k] = 0; cnt[k] = 0;
        end
      end
      s.id_rs1 = 5'($urandom_range(0, 7));
      s.id_rs2 = 5'($urandom_range(0, 7));
      s.use1   = 1'($urandom);
      s.use2   = 1'($urandom);
      s.ex_rs1 = 5'($urandom_range(0, 7));
      s.ex_rs2 = 5'($urandom_range(0, 7));
      s.ex_rd  = 5'($urandom_range(0, 7));
      s.ex_we  = 1'($urandom);
      s.ex_ld  = ($urandom_range(0, 3) == 0);
      s.mm_rd  = 5'($urandom_range(0, 7));
      s.mm_we  = 1'($urandom);
      s.wb_rd  = 5'($urandom_range(0, 7));
      s.wb_we  = 1'($urandom);
      s.br     = ($urandom_range(0, 5) == 0);
      s.req    = 1'($urandom);
      s.rdy    = ($urandom_range(0, 2) != 0);
      #1;
      e[0] = model(s, hlt[0]);
      e[1] = model(s, hlt[1]);
      checks++;
      if (oa !== e[0]) begin
        errors++; $display("FAIL rand_a n=%0d got %h exp %h", n, oa, e[0]);
      end
      checks++;
      if (ob !== e[1]) begin
        errors++; $display("FAIL rand_b n=%0d got %h exp %h", n, ob, e[1]);
      end
      checks++;
      if (ia.stall_cycles !== 32'(cnt[0])) begin
        errors++;
        $display("FAIL rand_cnt_a n=%0d got %0d exp %0d", n, ia.stall_cycles, cnt[0]);
      end
      checks++;
      if (ib.stall_cycles !== 4'(cnt[1])) begin
        errors++;
        $display("FAIL rand_cnt_b n=%0d got %0d exp %0d", n, ib.stall_cycles, cnt[1]);
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!hlt[k]) begin
          if (s.req && !s.rdy) begin
            run[k]++;
            if (run[k] >= to[k]) hlt[k] = 1'b1;
          end else begin
            run[k] = 0;
          end
        end
        if (e[k][11] && cnt[k] < cmax[k]) cnt[k]++;
      end
      #1;
    end
  endtask

  initial begin
    s = '0;
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_raw_nofwd();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
